bindct_transpose_buf: RTL

//  Ping-pong 8x8 transpose buffer between the row-pass and column-pass 1-D forward binDCT.

---
 rtl/bindct_pkg.sv | 15 +
 rtl/bindct_bank.sv | 29 ++
 rtl/bindct_transpose_buf.sv | 104 ++++++++++
 3 files changed

// File: rtl/bindct_pkg.sv
// Shared types and constants for the 2-D binDCT datapath.
// coef_t is the row-pass output format that travels through the transpose buffer.
package bindct_pkg;

  localparam int N = 8;
  localparam int DATA_WIDTH_DEFAULT = 18;

  typedef logic signed [DATA_WIDTH_DEFAULT-1:0] coef_t;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_t;

endpackage

// File: rtl/bindct_bank.sv
// One 8x8 coefficient bank of the transpose buffer.
// Rows are written whole; reads return one column, i.e. one lane taken from every row.
module bindct_bank
  import bindct_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [2:0]                     wr_row,
  input  logic [N-1:0][DATA_WIDTH-1:0]   wr_data,
  input  logic [2:0]                     rd_col,
  output logic [N-1:0][DATA_WIDTH-1:0]   rd_data
);

  // Contents are deliberately not reset; the full flags in the top decide what is valid.
  logic [N-1:0][DATA_WIDTH-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_col_mux
    assign rd_data[g] = mem[g][rd_col];
  end

endmodule

// File: rtl/bindct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the row and column binDCT passes.
// One bank fills with rows while the other drains as columns.
module bindct_transpose_buf
  import bindct_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0][DATA_WIDTH-1:0]   row_in,
  input  logic                           row_valid,
  output logic                           row_ready,
  output logic                           overflow,
  output logic [N-1:0][DATA_WIDTH-1:0]   col_out,
  output logic                           col_valid,
  input  logic                           col_ready,
  output logic [2:0]                     col_idx,
  output logic                           col_last
);

  logic                         wr_bank;
  logic                         rd_bank;
  logic [2:0]                   wr_row;
  logic [2:0]                   rd_col;
  logic [1:0]                   full;
  logic [1:0]                   full_next;
  rd_state_t                    rd_state;
  rd_state_t                    rd_state_next;
  logic                         row_acc;
  logic                         col_xfer;
  logic                         wr_done;
  logic                         rd_done;
  logic [N-1:0][DATA_WIDTH-1:0] bank_data [2];

  assign row_ready = !full[wr_bank];
  assign row_acc   = row_valid && row_ready;
  assign wr_done   = row_acc && (wr_row == 3'd7);
  assign col_valid = (rd_state == RD_STREAM);
  assign col_xfer  = col_valid && col_ready;
  assign rd_done   = col_xfer && (rd_col == 3'd7);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bindct_bank #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .wr_en   (row_acc && (wr_bank == 1'(b))),
      .wr_row  (wr_row),
      .wr_data (row_in),
      .rd_col  (rd_col),
      .rd_data (bank_data[b])
    );
  end

  // The read FSM looks at the flags as they will be after this edge, so a block
  // completing now streams next cycle and back-to-back blocks leave no bubble.
  always_comb begin
    full_next = full;
    if (wr_done) full_next[wr_bank] = 1'b1;
    if (rd_done) full_next[rd_bank] = 1'b0;
  end

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RD_IDLE: begin
        if (full_next[rd_bank]) rd_state_next = RD_STREAM;
      end
      RD_STREAM: begin
        if (rd_done) rd_state_next = full_next[~rd_bank] ? RD_STREAM : RD_IDLE;
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      wr_row   <= 3'd0;
      rd_bank  <= 1'b0;
      rd_col   <= 3'd0;
      full     <= 2'b00;
      overflow <= 1'b0;
    end else begin
      full <= full_next;
      if (row_acc) wr_row <= wr_row + 3'd1;
      if (wr_done) wr_bank <= ~wr_bank;
      if (col_xfer) rd_col <= rd_col + 3'd1;
      if (rd_done) rd_bank <= ~rd_bank;
      if (row_valid && !row_ready) overflow <= 1'b1;
    end
  end

  // Gate the column so nothing stale leaks out while idle.
  assign col_out  = col_valid ? bank_data[rd_bank] : '0;
  assign col_idx  = rd_col;
  assign col_last = col_valid && (rd_col == 3'd7);

endmodule
